// File: rtl/hazard_unit_pkg.sv
// Shared LC-3b types plus the hazard-unit state encoding and counter width.
// Imported by the hazard unit, its load-use comparator and the control interface.
package hazard_unit_pkg;

  typedef logic [2:0] lc3b_reg;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } hazard_state_t;

  localparam int HAZ_CNT_W = 2;

  // Loads whose data only exists at the end of MEM and so cannot be forwarded into EX in time.
  function automatic logic is_load(input lc3b_opcode op);
    return (op == op_ldr) || (op == op_ldb) || (op == op_ldi);
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline-control bundle between the datapath (master) and the hazard unit (slave).
// HAZARD_STATS_EN adds the stall_cycles / flush_count statistics outputs.
interface hazard_unit_if;
  import hazard_unit_pkg::*;

  logic       if_id_v;
  lc3b_reg    if_id_SR1;
  lc3b_reg    if_id_SR2;
  logic       if_id_sr1_needed;
  logic       if_id_sr2_needed;
  logic       id_ex_v;
  lc3b_opcode id_ex_opcode;
  lc3b_reg    id_ex_DR;
  logic       id_ex_dr_needed;
  logic       ex_mem_v;
  logic       branch_taken;
  logic       imem_read;
  logic       imem_resp;
  logic       dmem_access;
  logic       dmem_resp;

  logic       load_pc;
  logic       load_if_id;
  logic       load_id_ex;
  logic       load_reg;
  logic       id_ex_bubble;
  logic       flush;
  logic       stall;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cycles;
  logic [15:0] flush_count;
`endif

  modport master (
    output if_id_v, if_id_SR1, if_id_SR2, if_id_sr1_needed, if_id_sr2_needed,
           id_ex_v, id_ex_opcode, id_ex_DR, id_ex_dr_needed, ex_mem_v,
           branch_taken, imem_read, imem_resp, dmem_access, dmem_resp,
    input  load_pc, load_if_id, load_id_ex, load_reg, id_ex_bubble, flush, stall
`ifdef HAZARD_STATS_EN
           , stall_cycles, flush_count
`endif
  );

  modport slave (
    input  if_id_v, if_id_SR1, if_id_SR2, if_id_sr1_needed, if_id_sr2_needed,
           id_ex_v, id_ex_opcode, id_ex_DR, id_ex_dr_needed, ex_mem_v,
           branch_taken, imem_read, imem_resp, dmem_access, dmem_resp,
    output load_pc, load_if_id, load_id_ex, load_reg, id_ex_bubble, flush, stall
`ifdef HAZARD_STATS_EN
           , stall_cycles, flush_count
`endif
  );

endinterface

// File: rtl/hazard_unit_load_use_detect.sv
// Purely combinational load-use comparator: a load in EX writes a register the ID
// instruction actually reads. Kept standalone so a wider issue stage can replicate it.
module load_use_detect
  import hazard_unit_pkg::*;
(
  input  logic       i_if_id_v,
  input  lc3b_reg    i_sr1,
  input  lc3b_reg    i_sr2,
  input  logic       i_sr1_needed,
  input  logic       i_sr2_needed,
  input  logic       i_id_ex_v,
  input  lc3b_opcode i_opcode,
  input  lc3b_reg    i_dr,
  input  logic       i_dr_needed,
  output logic       o_lu_hit
);

  logic w_src_match;

  assign w_src_match = (i_sr1_needed & (i_sr1 == i_dr)) | (i_sr2_needed & (i_sr2 == i_dr));
  assign o_lu_hit    = i_if_id_v & i_id_ex_v & i_dr_needed & is_load(i_opcode) & w_src_match;

endmodule

// File: rtl/hazard_unit.sv
// LC-3b 5-stage pipeline control: load-use bubbles, taken-branch flush, memory freeze.
// Define HAZARD_STATS_EN to add saturating stall_cycles / flush_count counters.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int LOAD_USE_BUBBLES = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  hazard_unit_if.slave hz
);

  localparam logic [HAZ_CNT_W-1:0] CNT_INIT = HAZ_CNT_W'(LOAD_USE_BUBBLES - 1);

  hazard_state_t        r_state;
  hazard_state_t        w_state_nxt;
  logic [HAZ_CNT_W-1:0] r_cnt;
  logic [HAZ_CNT_W-1:0] w_cnt_nxt;

  logic w_lu_hit;
  logic w_mem_busy;
  logic w_branch_flush;

  logic w_load_pc;
  logic w_load_if_id;
  logic w_load_id_ex;
  logic w_load_reg;
  logic w_id_ex_bubble;
  logic w_flush;
  logic w_stall;

  load_use_detect u_lu_detect (
    .i_if_id_v    (hz.if_id_v),
    .i_sr1        (hz.if_id_SR1),
    .i_sr2        (hz.if_id_SR2),
    .i_sr1_needed (hz.if_id_sr1_needed),
    .i_sr2_needed (hz.if_id_sr2_needed),
    .i_id_ex_v    (hz.id_ex_v),
    .i_opcode     (hz.id_ex_opcode),
    .i_dr         (hz.id_ex_DR),
    .i_dr_needed  (hz.id_ex_dr_needed),
    .o_lu_hit     (w_lu_hit)
  );

  assign w_mem_busy     = (hz.imem_read & ~hz.imem_resp) | (hz.dmem_access & ~hz.dmem_resp);
  assign w_branch_flush = hz.branch_taken & hz.ex_mem_v;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A frozen pipeline holds the remaining bubble count, so an interrupted stall resumes intact.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_mem_busy) begin
      w_state_nxt = r_state;
    end else if (w_branch_flush) begin
      w_state_nxt = RUN;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        RUN: begin
          if (w_lu_hit && (LOAD_USE_BUBBLES > 1)) begin
            w_state_nxt = LU_STALL;
            w_cnt_nxt   = CNT_INIT;
          end
        end
        LU_STALL: begin
          if (r_cnt == HAZ_CNT_W'(1)) begin
            w_state_nxt = RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - HAZ_CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // NOTE: every output gets a default first so no path through this block can infer a latch.
  always_comb begin
    w_load_pc      = 1'b0;
    w_load_if_id   = 1'b0;
    w_load_id_ex   = 1'b0;
    w_load_reg     = 1'b0;
    w_id_ex_bubble = 1'b0;
    w_flush        = 1'b0;
    w_stall        = 1'b0;
    if (!reset_n || w_mem_busy) begin
      w_load_pc = 1'b0;
    end else if (w_branch_flush) begin
      w_load_pc    = 1'b1;
      w_load_if_id = 1'b1;
      w_load_id_ex = 1'b1;
      w_load_reg   = 1'b1;
      w_flush      = 1'b1;
    end else if ((r_state == LU_STALL) || w_lu_hit) begin
      w_load_id_ex   = 1'b1;
      w_load_reg     = 1'b1;
      w_id_ex_bubble = 1'b1;
      w_stall        = 1'b1;
    end else begin
      w_load_pc    = 1'b1;
      w_load_if_id = 1'b1;
      w_load_id_ex = 1'b1;
      w_load_reg   = 1'b1;
    end
  end

  assign hz.load_pc      = w_load_pc;
  assign hz.load_if_id   = w_load_if_id;
  assign hz.load_id_ex   = w_load_id_ex;
  assign hz.load_reg     = w_load_reg;
  assign hz.id_ex_bubble = w_id_ex_bubble;
  assign hz.flush        = w_flush;
  assign hz.stall        = w_stall;

`ifdef HAZARD_STATS_EN
  logic [15:0] r_stall_cycles;
  logic [15:0] r_flush_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (w_stall && (r_stall_cycles != 16'hFFFF)) r_stall_cycles <= r_stall_cycles + 16'd1;
      if (w_flush && (r_flush_count  != 16'hFFFF)) r_flush_count  <= r_flush_count + 16'd1;
    end
  end

  assign hz.stall_cycles = r_stall_cycles;
  assign hz.flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: one instance with a single load-use bubble,
// one with three; table of single-cycle vectors plus multi-cycle corner sequences.
module tb_hazard_unit;
  import hazard_unit_pkg::*;

  typedef struct packed {
    logic load_pc;
    logic load_if_id;
    logic load_id_ex;
    logic load_reg;
    logic id_ex_bubble;
    logic flush;
    logic stall;
  } outs_t;

  typedef struct {
    logic       if_id_v;
    lc3b_reg    sr1;
    lc3b_reg    sr2;
    logic       sr1n;
    logic       sr2n;
    logic       id_ex_v;
    lc3b_opcode op;
    lc3b_reg    dr;
    logic       drn;
    logic       ex_mem_v;
    logic       br;
    logic       imr;
    logic       imresp;
    logic       dma;
    logic       dmresp;
  } in_t;

  typedef struct {
    string name;
    in_t   in;
    outs_t exp;
  } vec_t;

  localparam outs_t ZERO    = 7'b0000000;
  localparam outs_t RUN_ALL = 7'b1111000;
  localparam outs_t STALL   = 7'b0011101;
  localparam outs_t FLUSH   = 7'b1111010;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  hazard_unit_if if1 ();
  hazard_unit_if if3 ();

  hazard_unit #(.LOAD_USE_BUBBLES(1)) u_dut1 (.clk(clk), .reset_n(reset_n), .hz(if1));
  hazard_unit #(.LOAD_USE_BUBBLES(3)) u_dut3 (.clk(clk), .reset_n(reset_n), .hz(if3));

  int    n_checks = 0;
  int    n_errors = 0;
  outs_t exp_q[$];
  string name_q[$];
  vec_t  vecs[$];

  function automatic in_t idle();
    in_t v;
    v.if_id_v = 1'b0; v.sr1 = 3'd0; v.sr2 = 3'd0; v.sr1n = 1'b0; v.sr2n = 1'b0;
    v.id_ex_v = 1'b0; v.op = op_add; v.dr = 3'd0; v.drn = 1'b0; v.ex_mem_v = 1'b0;
    v.br = 1'b0; v.imr = 1'b0; v.imresp = 1'b0; v.dma = 1'b0; v.dmresp = 1'b0;
    return v;
  endfunction

  function automatic in_t hzd(lc3b_opcode op, lc3b_reg dr, lc3b_reg sr1, logic sr1n,
                              lc3b_reg sr2, logic sr2n);
    in_t v = idle();
    v.if_id_v = 1'b1; v.id_ex_v = 1'b1; v.drn = 1'b1; v.op = op; v.dr = dr;
    v.sr1 = sr1; v.sr1n = sr1n; v.sr2 = sr2; v.sr2n = sr2n;
    return v;
  endfunction

  // LDR R1 in EX, ADD R2,R1,R3 in ID.
  function automatic in_t ldr_add();
    return hzd(op_ldr, 3'd1, 3'd1, 1'b1, 3'd3, 1'b1);
  endfunction

  // Bubble now in EX; ID still holds the dependent ADD.
  function automatic in_t bubble();
    in_t v = ldr_add();
    v.id_ex_v = 1'b0;
    return v;
  endfunction

  task automatic drive(input int d, input in_t v);
    if (d == 1) begin
      if1.if_id_v = v.if_id_v; if1.if_id_SR1 = v.sr1; if1.if_id_SR2 = v.sr2;
      if1.if_id_sr1_needed = v.sr1n; if1.if_id_sr2_needed = v.sr2n;
      if1.id_ex_v = v.id_ex_v; if1.id_ex_opcode = v.op; if1.id_ex_DR = v.dr;
      if1.id_ex_dr_needed = v.drn; if1.ex_mem_v = v.ex_mem_v; if1.branch_taken = v.br;
      if1.imem_read = v.imr; if1.imem_resp = v.imresp;
      if1.dmem_access = v.dma; if1.dmem_resp = v.dmresp;
    end else begin
      if3.if_id_v = v.if_id_v; if3.if_id_SR1 = v.sr1; if3.if_id_SR2 = v.sr2;
      if3.if_id_sr1_needed = v.sr1n; if3.if_id_sr2_needed = v.sr2n;
      if3.id_ex_v = v.id_ex_v; if3.id_ex_opcode = v.op; if3.id_ex_DR = v.dr;
      if3.id_ex_dr_needed = v.drn; if3.ex_mem_v = v.ex_mem_v; if3.branch_taken = v.br;
      if3.imem_read = v.imr; if3.imem_resp = v.imresp;
      if3.dmem_access = v.dma; if3.dmem_resp = v.dmresp;
    end
  endtask

  function automatic outs_t sample(input int d);
    if (d == 1)
      return {if1.load_pc, if1.load_if_id, if1.load_id_ex, if1.load_reg,
              if1.id_ex_bubble, if1.flush, if1.stall};
    return {if3.load_pc, if3.load_if_id, if3.load_id_ex, if3.load_reg,
            if3.id_ex_bubble, if3.flush, if3.stall};
  endfunction

  task automatic check(input string name, input outs_t act, input outs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got pc/ifid/idex/reg/bub/flush/stall=%b, expected %b", name, act, exp);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One cycle: drive at the falling edge, queue the expectation, compare mid-low-phase.
  task automatic step(input string name, input int d, input in_t v, input outs_t e);
    @(negedge clk);
    drive(d, v);
    exp_q.push_back(e);
    name_q.push_back(name);
    #1;
    check(name_q.pop_front(), sample(d), exp_q.pop_front());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    in_t v;

    reset_n = 1'b0;
    drive(1, ldr_add());
    drive(3, ldr_add());
    #1;
    check("reset_d1", sample(1), ZERO);
    check("reset_d3", sample(3), ZERO);
    drive(1, idle());
    drive(3, idle());
    @(negedge clk);
    #2 reset_n = 1'b1;

    vecs.push_back('{"idle", idle(), RUN_ALL});
    vecs.push_back('{"ldr_sr1_hit", ldr_add(), STALL});
    v = ldr_add(); v.sr1n = 1'b0;
    vecs.push_back('{"ldr_sr1_not_needed", v, RUN_ALL});
    vecs.push_back('{"ldb_sr2_hit", hzd(op_ldb, 3'd5, 3'd0, 1'b1, 3'd5, 1'b1), STALL});
    vecs.push_back('{"ldi_sr1_hit", hzd(op_ldi, 3'd7, 3'd7, 1'b1, 3'd0, 1'b0), STALL});
    vecs.push_back('{"add_in_ex", hzd(op_add, 3'd1, 3'd1, 1'b1, 3'd3, 1'b1), RUN_ALL});
    v = ldr_add(); v.drn = 1'b0;
    vecs.push_back('{"ldr_no_dr", v, RUN_ALL});
    v = ldr_add(); v.if_id_v = 1'b0;
    vecs.push_back('{"ifid_invalid", v, RUN_ALL});
    vecs.push_back('{"idex_invalid", bubble(), RUN_ALL});
    vecs.push_back('{"ldr_reg_mismatch", hzd(op_ldr, 3'd1, 3'd2, 1'b1, 3'd3, 1'b1), RUN_ALL});
    v = idle(); v.imr = 1'b1;
    vecs.push_back('{"imem_busy", v, ZERO});
    v.imresp = 1'b1;
    vecs.push_back('{"imem_resp", v, RUN_ALL});
    v = ldr_add(); v.dma = 1'b1;
    vecs.push_back('{"dmem_busy_over_lu", v, ZERO});
    v = ldr_add(); v.br = 1'b1; v.ex_mem_v = 1'b1;
    vecs.push_back('{"branch_over_lu", v, FLUSH});
    v = idle(); v.br = 1'b1;
    vecs.push_back('{"branch_no_exmem_v", v, RUN_ALL});
    v = idle(); v.br = 1'b1; v.ex_mem_v = 1'b1; v.dma = 1'b1;
    vecs.push_back('{"busy_over_branch", v, ZERO});

    foreach (vecs[i]) step(vecs[i].name, 1, vecs[i].in, vecs[i].exp);

    // Single-bubble load-use: one stall cycle, then the pipeline moves again.
    step("b1_hit", 1, ldr_add(), STALL);
    step("b1_after", 1, bubble(), RUN_ALL);

    // Branch held through a freeze is taken on the first non-busy cycle.
    v = idle(); v.br = 1'b1; v.ex_mem_v = 1'b1; v.dma = 1'b1;
    step("br_frozen", 1, v, ZERO);
    v.dma = 1'b0;
    step("br_released", 1, v, FLUSH);
    step("br_after", 1, idle(), RUN_ALL);

    // Three-bubble load-use: exactly three stall cycles.
    step("b3_hit", 3, ldr_add(), STALL);
    step("b3_bub2", 3, bubble(), STALL);
    step("b3_bub3", 3, bubble(), STALL);
    step("b3_run", 3, bubble(), RUN_ALL);

    // Freeze during LU_STALL keeps the remaining count.
    step("frz_hit", 3, ldr_add(), STALL);
    v = bubble(); v.dma = 1'b1;
    for (int i = 0; i < 4; i++) step($sformatf("frz_busy%0d", i), 3, v, ZERO);
    step("frz_bub2", 3, bubble(), STALL);
    step("frz_bub3", 3, bubble(), STALL);
    step("frz_run", 3, bubble(), RUN_ALL);

    // Taken branch aborts a stall in progress.
    step("abort_hit", 3, ldr_add(), STALL);
    v = bubble(); v.br = 1'b1; v.ex_mem_v = 1'b1;
    step("abort_flush", 3, v, FLUSH);
    step("abort_run", 3, bubble(), RUN_ALL);

    // Asynchronous reset in the middle of LU_STALL.
    step("rst_hit", 3, ldr_add(), STALL);
    step("rst_stall", 3, ldr_add(), STALL);
    #1 reset_n = 1'b0;
    #1;
    check("rst_async_d3", sample(3), ZERO);
    check("rst_async_d1", sample(1), ZERO);
`ifdef HAZARD_STATS_EN
    check16("rst_stall_cycles", if3.stall_cycles, 16'd0);
    check16("rst_flush_count", if3.flush_count, 16'd0);
`endif
    drive(3, bubble());
    drive(1, idle());
    @(negedge clk);
    #2 reset_n = 1'b1;
    step("rst_run0", 3, bubble(), RUN_ALL);
    step("rst_run1", 3, bubble(), RUN_ALL);

`ifdef HAZARD_STATS_EN
    step("stats_hit", 1, ldr_add(), STALL);
    v = idle(); v.br = 1'b1; v.ex_mem_v = 1'b1;
    step("stats_flush", 1, v, FLUSH);
    step("stats_idle", 1, idle(), RUN_ALL);
    check16("stats_stall_cycles", if1.stall_cycles, 16'd1);
    check16("stats_flush_count", if1.flush_count, 16'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
